// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and sync-lock state encoding
package vga_pkg;

    localparam int C_VISIBLE_COLUMNS = 640;
    localparam int C_VISIBLE_ROWS    = 480;
    localparam int C_TOTAL_COLUMNS   = 800;
    localparam int C_TOTAL_ROWS      = 525;
    localparam int COUNT_W           = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

endpackage

// File: rtl/vga_sync_lock_fsm.sv
// rtl/vga_sync_lock_fsm.sv - frame-start consistency tracker producing lock and error flags
module vga_sync_lock_fsm
    import vga_pkg::*;
#(
    parameter int c_TOTAL_COLUMNS = C_TOTAL_COLUMNS,
    parameter int c_TOTAL_ROWS    = C_TOTAL_ROWS
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_FrameStart,
    input  logic [COUNT_W-1:0] i_ColCount,
    input  logic [COUNT_W-1:0] i_RowCount,
    output logic               o_Locked,
    output logic               o_SyncError
);

    localparam logic [COUNT_W-1:0] LAST_COL = COUNT_W'(c_TOTAL_COLUMNS - 1);
    localparam logic [COUNT_W-1:0] LAST_ROW = COUNT_W'(c_TOTAL_ROWS - 1);

    lock_state_t r_state;
    logic        w_at_end;

    // A well-formed frame start lands exactly where the free-running count would wrap.
    assign w_at_end = (i_ColCount == LAST_COL) && (i_RowCount == LAST_ROW);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state     <= SEARCH;
            o_Locked    <= 1'b0;
            o_SyncError <= 1'b0;
        end else begin
            o_SyncError <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (i_FrameStart) begin
                        r_state  <= CHECK;
                        o_Locked <= 1'b0;
                    end
                end
                CHECK: begin
                    if (i_FrameStart) begin
                        if (w_at_end) begin
                            r_state  <= LOCKED;
                            o_Locked <= 1'b1;
                        end else begin
                            o_SyncError <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (i_FrameStart && !w_at_end) begin
                        r_state     <= CHECK;
                        o_Locked    <= 1'b0;
                        o_SyncError <= 1'b1;
                    end else if (!i_FrameStart && w_at_end) begin
                        r_state     <= SEARCH;
                        o_Locked    <= 1'b0;
                        o_SyncError <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    o_Locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_sync_to_count.sv
// rtl/vga_sync_to_count.sv - regenerates column/row counters from delayed active-video syncs
module vga_sync_to_count
    import vga_pkg::*;
#(
    parameter int c_VISIBLE_COLUMNS = C_VISIBLE_COLUMNS,
    parameter int c_VISIBLE_ROWS    = C_VISIBLE_ROWS,
    parameter int c_TOTAL_COLUMNS   = C_TOTAL_COLUMNS,
    parameter int c_TOTAL_ROWS      = C_TOTAL_ROWS
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_HSync,
    input  logic               i_VSync,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic [COUNT_W-1:0] o_ColCount,
    output logic [COUNT_W-1:0] o_RowCount,
    output logic               o_FrameStart,
    output logic               o_Locked,
    output logic               o_SyncError
);

    localparam logic [COUNT_W-1:0] LAST_COL = COUNT_W'(c_TOTAL_COLUMNS - 1);
    localparam logic [COUNT_W-1:0] LAST_ROW = COUNT_W'(c_TOTAL_ROWS - 1);

    if (c_VISIBLE_COLUMNS > c_TOTAL_COLUMNS || c_VISIBLE_ROWS > c_TOTAL_ROWS) begin : g_bad_geometry
        $error("visible area exceeds total frame size");
    end

    logic r_VSync;
    logic w_fs;

    assign w_fs = i_VSync && !r_VSync;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_VSync      <= 1'b0;
            o_HSync      <= 1'b0;
            o_VSync      <= 1'b0;
            o_FrameStart <= 1'b0;
            o_ColCount   <= '0;
            o_RowCount   <= '0;
        end else begin
            r_VSync      <= i_VSync;
            o_HSync      <= i_HSync;
            o_VSync      <= i_VSync;
            o_FrameStart <= w_fs;
            // Frame start and the natural wrap agree when the source geometry matches.
            if (w_fs) begin
                o_ColCount <= '0;
                o_RowCount <= '0;
            end else if (o_ColCount == LAST_COL) begin
                o_ColCount <= '0;
                o_RowCount <= (o_RowCount == LAST_ROW) ? '0 : o_RowCount + 1'b1;
            end else begin
                o_ColCount <= o_ColCount + 1'b1;
            end
        end
    end

    vga_sync_lock_fsm #(
        .c_TOTAL_COLUMNS(c_TOTAL_COLUMNS),
        .c_TOTAL_ROWS   (c_TOTAL_ROWS)
    ) u_lock_fsm (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_FrameStart(w_fs),
        .i_ColCount  (o_ColCount),
        .i_RowCount  (o_RowCount),
        .o_Locked    (o_Locked),
        .o_SyncError (o_SyncError)
    );

endmodule

// File: tb/tb_vga_sync_to_count.sv
// tb/tb_vga_sync_to_count.sv - randomized self-checking bench against a linear-position frame model
module tb_vga_sync_to_count;

    localparam int VC = 8;
    localparam int VR = 4;
    localparam int TC = 10;
    localparam int TR = 6;
    localparam int N  = TC * TR;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_HSync = 1'b0;
    logic       i_VSync = 1'b0;
    logic       o_HSync, o_VSync, o_FrameStart, o_Locked, o_SyncError;
    logic [9:0] o_ColCount, o_RowCount;

    vga_sync_to_count #(
        .c_VISIBLE_COLUMNS(VC),
        .c_VISIBLE_ROWS   (VR),
        .c_TOTAL_COLUMNS  (TC),
        .c_TOTAL_ROWS     (TR)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_HSync     (i_HSync),
        .i_VSync     (i_VSync),
        .o_HSync     (o_HSync),
        .o_VSync     (o_VSync),
        .o_ColCount  (o_ColCount),
        .o_RowCount  (o_RowCount),
        .o_FrameStart(o_FrameStart),
        .o_Locked    (o_Locked),
        .o_SyncError (o_SyncError)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the frame is a linear position 0..N-1; lock state 0=search 1=check 2=locked.
    int   m_pos, m_state;
    logic m_rv, m_hs, m_vs, m_fs, m_lock, m_err;

    task automatic model_reset();
        m_pos = 0; m_state = 0; m_rv = 0;
        m_hs = 0; m_vs = 0; m_fs = 0; m_lock = 0; m_err = 0;
    endtask

    task automatic model_step(input logic hs, input logic vs);
        bit fs, at_end;
        int nxt;
        fs = vs && !m_rv;
        at_end = (m_pos == N - 1);
        nxt = m_state;
        m_err = 0;
        if (fs) begin
            if (m_state == 0) nxt = 1;
            else if (at_end) nxt = 2;
            else begin nxt = 1; m_err = 1; end
        end else if (m_state == 2 && at_end) begin
            nxt = 0; m_err = 1;
        end
        m_state = nxt;
        m_pos = fs ? 0 : (m_pos + 1) % N;
        m_rv = vs; m_hs = hs; m_vs = vs; m_fs = fs;
        m_lock = (nxt == 2);
    endtask

    function automatic logic [31:0] observed();
        return {7'd0, o_ColCount, o_RowCount, o_HSync, o_VSync, o_FrameStart, o_Locked, o_SyncError};
    endfunction

    function automatic logic [31:0] expected();
        return {7'd0, 10'(m_pos % TC), 10'(m_pos / TC), m_hs, m_vs, m_fs, m_lock, m_err};
    endfunction

    int src_col = 0, src_row = 0;
    bit vs_mask = 0, hs_noise = 0;

    task automatic drive();
        i_HSync = hs_noise ? 1'($urandom_range(0, 1)) : (src_col < VC);
        i_VSync = !vs_mask && (src_row < VR);
    endtask

    task automatic gen_advance();
        src_col++;
        if (src_col == TC) begin
            src_col = 0;
            src_row = (src_row + 1) % TR;
        end
    endtask

    task automatic tick(input bit adv);
        @(posedge i_Clk);
        #1;
        if (i_Rst_n) model_step(i_HSync, i_VSync);
        else model_reset();
        check("cycle", observed(), expected());
        err_seen += int'(o_SyncError);
        if (adv) gen_advance();
        drive();
    endtask

    task automatic to_boundary();
        for (int k = 0; k < N + 8 && !(src_col == 0 && src_row == 0); k++) tick(1);
        check("boundary_reached", (src_col == 0 && src_row == 0), 1);
    endtask

    initial begin
        bit found;
        model_reset();
        drive();
        repeat (3) tick(0);
        i_Rst_n = 1'b1;

        tick(1);
        check("fs_first_pulse", o_FrameStart, 1);
        check("fs_first_count", {o_ColCount, o_RowCount}, 0);
        repeat (2 * N - 1) tick(1);
        check("locked_after_two_fs", o_Locked, 1);

        err_seen = 0;
        repeat (N) tick(1);
        check("clean_wrap_no_err", err_seen, 0);
        check("clean_wrap_locked", o_Locked, 1);

        repeat (25) tick(1);
        err_seen = 0;
        repeat (3) tick(0);
        to_boundary();
        tick(1);
        check("stall_err_once", err_seen, 1);
        check("stall_unlocked", o_Locked, 0);
        repeat (N) tick(1);
        check("stall_relock", o_Locked, 1);
        to_boundary();

        err_seen = 0;
        vs_mask = 1; drive();
        repeat (N) tick(1);
        vs_mask = 0; drive();
        check("missed_err_once", err_seen, 1);
        check("missed_unlocked", o_Locked, 0);
        repeat (2 * N) tick(1);
        check("missed_relock", o_Locked, 1);

        found = 0;
        for (int k = 0; k < 2 * N && !found; k++) begin
            tick(1);
            found = (o_ColCount == 10'd4 && o_RowCount == 10'd2);
        end
        check("reach_4_2", found, 1);
        #2 i_Rst_n = 1'b0;
        #1 model_reset();
        check("async_reset_outputs", observed(), 0);
        for (int k = 0; k < N && src_row != VR; k++) tick(1);
        i_Rst_n = 1'b1;
        to_boundary();
        tick(1);
        check("rst_first_fs_pulse", o_FrameStart, 1);
        check("rst_first_fs_unlocked", o_Locked, 0);
        repeat (N) tick(1);
        check("rst_second_fs_locked", o_Locked, 1);
        to_boundary();

        repeat (24) begin
            case ($urandom_range(0, 3))
                0: repeat (N) tick(1);
                1: begin
                    repeat ($urandom_range(1, N - 2)) tick(1);
                    repeat ($urandom_range(1, 5)) tick(0);
                    to_boundary();
                end
                2: begin
                    vs_mask = 1; drive();
                    repeat (N) tick(1);
                    vs_mask = 0; drive();
                end
                default: begin
                    hs_noise = 1; drive();
                    repeat (N) tick(1);
                    hs_noise = 0; drive();
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
